// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - widths (PC/address, instruction, imem read bus)
//   - reset PC and the NOP placed in the instruction register after reset
//   - FSM state encoding (2-bit)
//   - packed record describing one fetched instruction (inst / pc / fault)
package ifu_fetch_pkg;

  localparam int IFU_XLEN   = 64;
  localparam int IFU_INST_W = 32;
  localparam int IFU_BUS_W  = 64;

  localparam logic [IFU_XLEN-1:0]   IFU_PC_RST   = '0;
  localparam logic [IFU_INST_W-1:0] IFU_INST_NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issue read for pc_i
    S_WAIT = 2'd1,  // read outstanding, result wanted
    S_HOLD = 2'd2,  // instruction presented to decode
    S_DROP = 2'd3   // read outstanding, result flushed
  } state_t;

  typedef struct packed {
    logic [IFU_INST_W-1:0] inst;
    logic [IFU_XLEN-1:0]   pc;
    logic                  fault;
  } ifu_inst_t;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage, directly downstream of the PC register.
// Reads one aligned 64-bit beat per PC, picks the 32-bit half addressed by
// pc[2], hands it to decode over valid/ready and pulses pc_adv_o on accept.
// At most one imem read is in flight; a flush while it is in flight turns it
// into a drop so the late response is swallowed.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   pc_i / pc_adv_o     current PC in, 1-cycle "advance PC" pulse out
//   redirect_i          flush from execute (PC register reloads same cycle)
//   imem_req_*          read request (valid/ready, aligned address)
//   imem_rsp_*          read response (valid, data, access fault)
//   inst_*              instruction to decode (valid/ready, inst, pc, fault)
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN   = IFU_XLEN,
  parameter int INST_W = IFU_INST_W,
  parameter int BUS_W  = IFU_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_i,
  output logic              pc_adv_o,
  input  logic              redirect_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [XLEN-1:0]   imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [BUS_W-1:0]  imem_rsp_data_i,
  input  logic              imem_rsp_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   inst_pc_o,
  output logic              inst_fault_o
);

  state_t              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                fault_q, fault_d;
  logic                pc_misaligned;

  assign pc_misaligned   = |pc_i[1:0];
  assign imem_req_addr_o = {pc_i[XLEN-1:3], 3'b000};
  assign inst_valid_o    = (state_q == S_HOLD);
  assign inst_o          = inst_q;
  assign inst_pc_o       = inst_pc_q;
  assign inst_fault_o    = fault_q;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    inst_d           = inst_q;
    inst_pc_d        = inst_pc_q;
    fault_d          = fault_q;
    imem_req_valid_o = 1'b0;
    pc_adv_o         = 1'b0;
    case (state_q)
      S_REQ: begin
        if (!redirect_i) begin
          if (pc_misaligned) begin
            // Misaligned PC never reaches memory; report it as a faulting slot.
            inst_d    = '0;
            fault_d   = 1'b1;
            inst_pc_d = pc_i;
            state_d   = S_HOLD;
          end else begin
            imem_req_valid_o = 1'b1;
            if (imem_req_ready_i) begin
              pc_d    = pc_i;
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          // Response arriving with the flush is simply dropped; otherwise
          // it is still owed to us and must be swallowed later.
          state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
        end else if (imem_rsp_valid_i) begin
          inst_d    = pc_q[2] ? imem_rsp_data_i[2*INST_W-1:INST_W]
                              : imem_rsp_data_i[INST_W-1:0];
          fault_d   = imem_rsp_err_i;
          inst_pc_d = pc_q;
          state_d   = S_HOLD;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid_i) state_d = S_REQ;
      end
      S_HOLD: begin
        // Flush wins over a same-cycle accept: the PC register is taking the
        // redirect target, so it must not also see an advance.
        if (redirect_i) begin
          state_d = S_REQ;
        end else if (inst_ready_i) begin
          pc_adv_o = 1'b1;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    // State already sits in S_REQ during reset; keep strobes quiet regardless.
    if (!rst) begin
      imem_req_valid_o = 1'b0;
      pc_adv_o         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      pc_q      <= IFU_PC_RST;
      inst_q    <= IFU_INST_NOP;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  // Responses are only legal while a read is outstanding.
  ap_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid_i |-> (state_q == S_WAIT || state_q == S_DROP));

  // A stalled request holds its address unless flushed.
  ap_req_stable: assert property (@(posedge clk) disable iff (!rst)
    (imem_req_valid_o && !imem_req_ready_i) |=>
      (redirect_i || (imem_req_valid_o && $stable(imem_req_addr_o))));

endmodule
